// File: rtl/casex_match_pkg.sv
// Shared types for the casex pattern matcher: FSM states,
// table entry record and a clog2 helper.
package casex_match_pkg;

  localparam int MAXW = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    LOCKED = 2'd2
  } fsm_t;

  // value/mask are zero-extended from WIDTH to MAXW
  typedef struct packed {
    logic            en;
    logic            out;
    logic [MAXW-1:0] mask;
    logic [MAXW-1:0] value;
  } entry_t;

  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/casex_match_chan.sv
// One channel: priority matcher over the shared table,
// hold counter, lock FSM and registered outputs.
module casex_match_chan
  import casex_match_pkg::*;
#(
  parameter int   WIDTH       = 3,
  parameter int   NPAT        = 4,
  parameter int   HOLD        = 2,
  parameter logic DEFAULT_OUT = 1'b0,
  localparam int  IW          = clog2(NPAT),
  localparam int  CW          = clog2(HOLD + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  entry_t           tbl [NPAT],
  input  logic             cfg_we,
  input  logic [IW-1:0]    cfg_addr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] st,
  output logic             dataOut,
  output logic             locked,
  output logic [IW-1:0]    match_idx
);

  fsm_t          fsm;
  logic [CW-1:0] cnt;
  logic          hit;
  logic [IW-1:0] hidx;
  logic [CW:0]   nxt;
  logic          done;
  logic          kill;

  // scan high to low so the lowest index wins
  always_comb begin
    hit  = 1'b0;
    hidx = '0;
    for (int i = NPAT - 1; i >= 0; i--) begin
      if (tbl[i].en &&
          (((MAXW'(st) ^ tbl[i].value)
            & ~tbl[i].mask) == '0)) begin
        hit  = 1'b1;
        hidx = IW'(i);
      end
    end
  end

  assign nxt  = {1'b0, cnt} + (CW+1)'(1);
  assign done = nxt >= (CW+1)'(HOLD);
  // rewriting the tracked entry aborts the run
  assign kill = cfg_we && (cfg_addr == match_idx)
                && (fsm != IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fsm       <= IDLE;
      cnt       <= '0;
      match_idx <= '0;
      locked    <= 1'b0;
      dataOut   <= DEFAULT_OUT;
    end else if (kill) begin
      fsm     <= IDLE;
      cnt     <= '0;
      locked  <= 1'b0;
      dataOut <= DEFAULT_OUT;
    end else if (in_valid) begin
      unique case (fsm)
        IDLE: begin
          if (hit) begin
            match_idx <= hidx;
            cnt       <= CW'(1);
            if (HOLD == 1) begin
              fsm     <= LOCKED;
              locked  <= 1'b1;
              dataOut <= tbl[hidx].out;
            end else begin
              fsm <= COUNT;
            end
          end
        end
        COUNT: begin
          if (!hit) begin
            fsm <= IDLE;
            cnt <= '0;
          end else if (hidx == match_idx) begin
            if (done) begin
              fsm     <= LOCKED;
              cnt     <= CW'(HOLD);
              locked  <= 1'b1;
              dataOut <= tbl[hidx].out;
            end else begin
              cnt <= nxt[CW-1:0];
            end
          end else begin
            match_idx <= hidx;
            cnt       <= CW'(1);
          end
        end
        LOCKED: begin
          if (!hit) begin
            fsm     <= IDLE;
            cnt     <= '0;
            locked  <= 1'b0;
            dataOut <= DEFAULT_OUT;
          end else if (hidx != match_idx) begin
            fsm       <= COUNT;
            match_idx <= hidx;
            cnt       <= CW'(1);
            locked    <= 1'b0;
            dataOut   <= DEFAULT_OUT;
          end
        end
        default: begin
          fsm <= IDLE;
          cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/casex_match_fsm.sv
// Programmable wildcard matcher: shared value/mask table
// plus one hold-to-lock channel per input bus.
module casex_match_fsm
  import casex_match_pkg::*;
#(
  parameter int   WIDTH       = 3,
  parameter int   NPAT        = 4,
  parameter int   CHANNELS    = 2,
  parameter int   HOLD        = 2,
  parameter logic DEFAULT_OUT = 1'b0,
  localparam int  IW          = clog2(NPAT)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      cfg_we,
  input  logic [IW-1:0]             cfg_addr,
  input  logic [WIDTH-1:0]          cfg_value,
  input  logic [WIDTH-1:0]          cfg_mask,
  input  logic                      cfg_out,
  input  logic                      cfg_en,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] state,
  output logic [CHANNELS-1:0]       dataOut,
  output logic [CHANNELS-1:0]       locked,
  output logic [CHANNELS*IW-1:0]    match_idx
);

  entry_t tbl [NPAT];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NPAT; i++)
        tbl[i] <= '0;
    end else if (cfg_we && (int'(cfg_addr) < NPAT)) begin
      tbl[cfg_addr] <= '{en:    cfg_en,
                         out:   cfg_out,
                         mask:  MAXW'(cfg_mask),
                         value: MAXW'(cfg_value)};
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    casex_match_chan #(
      .WIDTH      (WIDTH),
      .NPAT       (NPAT),
      .HOLD       (HOLD),
      .DEFAULT_OUT(DEFAULT_OUT)
    ) u_chan (
      .clk      (clk),
      .rstn     (rstn),
      .tbl      (tbl),
      .cfg_we   (cfg_we),
      .cfg_addr (cfg_addr),
      .in_valid (in_valid[c]),
      .st       (state[c*WIDTH +: WIDTH]),
      .dataOut  (dataOut[c]),
      .locked   (locked[c]),
      .match_idx(match_idx[c*IW +: IW])
    );
  end

endmodule
